// File: rtl/wb_regfile_pkg.sv
// Shared MIPS datapath definitions: widths, register-zero index and common word/index types.
// Used by the writeback stage, the MEM/WB register and the forwarding unit.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam int unsigned REG_ZERO = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regidx_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB register / ID stage and the writeback register file.
// The master drives writeback and read-address fields; the slave returns read data and debug status.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W
);

    logic [DATA_W-1:0] data_WB_IN;
    logic [DATA_W-1:0] resALU_WB_IN;
    logic [ADDR_W-1:0] mux2Output_WB_IN;
    logic              RegWrite_WB_IN;
    logic              MemtoReg_WB_IN;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic [31:0]       wb_count;

    modport master (
        output data_WB_IN, resALU_WB_IN, mux2Output_WB_IN, RegWrite_WB_IN, MemtoReg_WB_IN,
        output rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_we, wb_count
    );

    modport slave (
        input  data_WB_IN, resALU_WB_IN, mux2Output_WB_IN, RegWrite_WB_IN, MemtoReg_WB_IN,
        input  rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_we, wb_count
    );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Writeback value select: load data or ALU result.
// Kept standalone so the forwarding unit can instantiate the same select.
module wb_mux #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic [DATA_W-1:0] wb_data_o
);

    always_comb begin
        wb_data_o = sel_i ? mem_data_i : alu_data_i;
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 2^ADDR_W x DATA_W architectural register file with two read ports,
// same-cycle write-to-read bypass and a committed-write counter.
module wb_regfile #(
    parameter int unsigned DATA_W    = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W    = mips_pkg::ADDR_W,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic         clk_wb_regfile,
    input  logic         rst_n_wb_regfile,
    wb_regfile_if.slave  bus
);

    import mips_pkg::*;

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [31:0]       wb_count_q;
    logic [31:0]       wb_count_d;

    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .sel_i      (bus.MemtoReg_WB_IN),
        .mem_data_i (bus.data_WB_IN),
        .alu_data_i (bus.resALU_WB_IN),
        .wb_data_o  (wb_data)
    );

    // Reset gates the write enable combinationally, which also disables bypass while low.
    always_comb begin
        wb_we = rst_n_wb_regfile && bus.RegWrite_WB_IN
                && (bus.mux2Output_WB_IN != ADDR_W'(REG_ZERO));
        hit_a = BYPASS_EN && wb_we && (bus.rs_addr == bus.mux2Output_WB_IN);
        hit_b = BYPASS_EN && wb_we && (bus.rt_addr == bus.mux2Output_WB_IN);
        wb_count_d = wb_we ? (wb_count_q + 32'd1) : wb_count_q;
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rst_n_wb_regfile && (bus.rs_addr != ADDR_W'(REG_ZERO))) begin
            rs_data = hit_a ? wb_data : regs_q[bus.rs_addr];
        end
        if (rst_n_wb_regfile && (bus.rt_addr != ADDR_W'(REG_ZERO))) begin
            rt_data = hit_b ? wb_data : regs_q[bus.rt_addr];
        end
    end

    always_ff @(posedge clk_wb_regfile or negedge rst_n_wb_regfile) begin
        if (!rst_n_wb_regfile) begin
            regs_q     <= '{default: '0};
            wb_count_q <= '0;
        end else begin
            if (wb_we) begin
                regs_q[bus.mux2Output_WB_IN] <= wb_data;
            end
            wb_count_q <= wb_count_d;
        end
    end

    assign bus.rs_data  = rs_data;
    assign bus.rt_data  = rt_data;
    assign bus.wb_data  = wb_data;
    assign bus.wb_we    = wb_we;
    assign bus.wb_count = wb_count_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus architectural register file of the 5-stage MIPS pipeline.
- Sits directly downstream of the MEM/WB pipeline register and consumes its outputs: memory data, ALU result, destination register, RegWrite, MemtoReg.
- Selects the writeback value and commits it to a 32x32 register file.
- Serves the two ID-stage read ports, with same-cycle write-to-read bypass, and keeps a committed-write counter for debug.

Parameters:
- DATA_W, 32, register and datapath width.
- ADDR_W, 5, register index width (2^ADDR_W registers).
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the new value; 0 = returns the stored value.

Ports:
- clk_wb_regfile  in  1  clock; all state updates on the rising edge.
- rst_n_wb_regfile  in  1  asynchronous, active-low reset.
- data_WB_IN  in  DATA_W  data-memory read value from MEM/WB.
- resALU_WB_IN  in  DATA_W  ALU result from MEM/WB.
- mux2Output_WB_IN  in  ADDR_W  destination register index.
- RegWrite_WB_IN  in  1  write enable.
- MemtoReg_WB_IN  in  1  1 selects data_WB_IN, 0 selects resALU_WB_IN.
- rs_addr  in  ADDR_W  read port A index (ID stage).
- rt_addr  in  ADDR_W  read port B index (ID stage).
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- wb_data  out  DATA_W  selected writeback value, for the forwarding unit.
- wb_we  out  1  effective write this cycle (RegWrite_WB_IN and dest != 0, reset deasserted).
- wb_count  out  32  number of committed writes.

Behaviour:
- Clock and reset: one clock, clk_wb_regfile. Reset rst_n_wb_regfile is asynchronous and active-low.
- Reset:
  - On assertion, immediately: all registers = 0, wb_count = 0.
  - While low: no write occurs, wb_we = 0, bypass is disabled, rs_data = rt_data = 0.
  - wb_data is still driven combinationally.
- Writeback mux (combinational, zero latency): wb_data = MemtoReg_WB_IN ? data_WB_IN : resALU_WB_IN.
- Write:
  - On the rising edge with wb_we = 1, reg[mux2Output_WB_IN] <= wb_data.
  - Latency 1 cycle to storage.
- Register 0:
  - Reads always return 0.
  - Writes to index 0 are discarded, set wb_we = 0 and do not increment wb_count.
- Reads (combinational): rs_data = (rs_addr == 0) ? 0 : (bypass_hit_A ? wb_data : reg[rs_addr]). rt_data is identical, using rt_addr.
- Bypass hit: bypass_hit_X = BYPASS_EN and wb_we and (X_addr == mux2Output_WB_IN).
- Both ports may read the same register, including the one being written; both see the bypassed value.
- Counter:
  - wb_count increments by 1 on every edge with wb_we = 1.
  - Wraps from 0xFFFFFFFF to 0 with no flag.
- Reset mid-operation: a write pending on the same edge as reset assertion is lost. The first write after release takes effect on the first rising edge with rst_n high.
- Unknown/X on RegWrite_WB_IN is not tolerated; the bench holds it defined after reset.
- Width rules: no sign or zero extension; all data paths are DATA_W wide.
- No state machine is required beyond the storage array and counter.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS = 2^ADDR_W;
  - localparam REG_ZERO = 0;
  - typedef word_t (DATA_W bits) and regidx_t (ADDR_W bits), shared with the MEM/WB register and the forwarding unit.
- One sub-module is natural: wb_mux, a 2:1 writeback select kept separate so the forwarding unit can reuse it.
- The register array, bypass and counter stay in wb_regfile.

Test Plan:
1. Reset then read: assert rst_n low mid-simulation after writing r5 = 0x12345678 -> rs_data(r5) = 0 immediately, wb_count = 0.
2. ALU writeback: RegWrite=1, MemtoReg=0, resALU=0xDEADBEEF, dest=8; next cycle rs_addr=8 -> rs_data = 0xDEADBEEF, wb_count = 1.
3. Load writeback with bypass:
   - Stimulus: MemtoReg=1, data=0x0000CAFE, dest=9, rs_addr=rt_addr=9 in the same cycle.
   - Response: rs_data = rt_data = 0x0000CAFE before the edge.
   - With BYPASS_EN=0, the old value is returned instead.
4. r0 protection: RegWrite=1, dest=0, value=0xFFFFFFFF -> wb_we = 0, rs_data(r0) = 0, wb_count unchanged.
5. RegWrite=0 with dest=3, value=0x55 -> r3 keeps its prior value 0xAA, no count increment.
6. Counter wrap: force wb_count to 0xFFFFFFFF via 2^32 writes or a backdoor preload, then one valid write -> wb_count = 0.
